// File: rtl/key_lock_ctrl_pkg.sv
// Shared key numbering and FSM state type for the keypad code-lock controller.
package key_lock_ctrl_pkg;

    localparam int KEY_ENTER = 8;
    localparam int NUM_KEYS  = 9;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_UNLOCK = 2'd1,
        ST_LOCK   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/key_lock_ctrl_timer.sv
// Loadable down-counter shared by the idle, unlock-hold and lockout timing.
module key_lock_ctrl_timer #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // A load always wins over counting so a fresh key restarts the interval.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/key_lock_ctrl.sv
// Code-lock controller: turns one-hot keypad pulses into a digit buffer, compares
// it on ENTER, and drives a timed unlock or a timed alarm after repeated failures.
module key_lock_ctrl
    import key_lock_ctrl_pkg::*;
#(
    parameter int                  PW_LEN         = 4,
    parameter logic [4*PW_LEN-1:0] PASSWORD       = 16'h1234,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  UNLOCK_CYCLES  = 24000000,
    parameter int                  LOCKOUT_CYCLES = 240000000,
    parameter int                  IDLE_CYCLES    = 120000000,
    parameter int                  CNT_W          = 28
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_KEYS-1:0]   key_pulse,
    output logic [4*PW_LEN-1:0]   entry_code,
    output logic [3:0]            digit_cnt,
    output logic                  unlock,
    output logic                  alarm,
    output logic                  err_pulse,
    output logic [2:0]            fail_cnt
);

    localparam logic [2:0] FAIL_LIM = 3'(MAX_FAIL);
    localparam logic [3:0] FULL_CNT = 4'(PW_LEN);

    lock_state_t          state_q;
    logic [4*PW_LEN-1:0]  entry_q;
    logic [3:0]           digit_cnt_q;
    logic                 unlock_q;
    logic                 alarm_q;
    logic                 err_q;
    logic [2:0]           fail_q;

    logic                 key_valid;
    logic [3:0]           key_idx;
    logic                 is_enter;
    logic [4*PW_LEN-1:0]  entry_shift;
    logic                 code_ok;
    logic [2:0]           fail_next;
    logic                 lock_hit;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic                 tmr_en;
    logic [CNT_W-1:0]     tmr_count;
    logic                 tmr_zero;

    // Only a single set bit is a key event; chords and empty cycles are ignored.
    always_comb begin
        key_valid = (key_pulse != '0) &&
                    ((key_pulse & (key_pulse - NUM_KEYS'(1))) == '0);
        key_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_pulse[i]) begin
                key_idx = 4'(i);
            end
        end
        is_enter    = (key_idx == 4'(KEY_ENTER));
        entry_shift = entry_q << 4;
        entry_shift[3:0] = key_idx + 4'd1;
        code_ok   = (digit_cnt_q == FULL_CNT) && (entry_q == PASSWORD);
        fail_next = fail_q + 3'd1;
        lock_hit  = (fail_next >= FAIL_LIM);
    end

    // Hold periods load N-1 so the output stays high for exactly N cycles.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (state_q == ST_ENTRY && key_valid) begin
            tmr_load = 1'b1;
            if (is_enter && code_ok) begin
                tmr_load_val = CNT_W'(UNLOCK_CYCLES - 1);
            end else if (is_enter && lock_hit) begin
                tmr_load_val = CNT_W'(LOCKOUT_CYCLES - 1);
            end else begin
                tmr_load_val = CNT_W'(IDLE_CYCLES);
            end
        end
        tmr_en = (tmr_count != '0);
    end

    key_lock_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_ENTRY;
            entry_q     <= '0;
            digit_cnt_q <= '0;
            unlock_q    <= 1'b0;
            alarm_q     <= 1'b0;
            err_q       <= 1'b0;
            fail_q      <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                ST_ENTRY: begin
                    if (key_valid && is_enter) begin
                        entry_q     <= '0;
                        digit_cnt_q <= '0;
                        if (code_ok) begin
                            state_q  <= ST_UNLOCK;
                            unlock_q <= 1'b1;
                            fail_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                            if (lock_hit) begin
                                state_q <= ST_LOCK;
                                alarm_q <= 1'b1;
                                fail_q  <= '0;
                            end else begin
                                fail_q <= fail_next;
                            end
                        end
                    end else if (key_valid) begin
                        if (digit_cnt_q < FULL_CNT) begin
                            entry_q     <= entry_shift;
                            digit_cnt_q <= digit_cnt_q + 4'd1;
                        end
                    end else if (tmr_zero && digit_cnt_q != '0) begin
                        entry_q     <= '0;
                        digit_cnt_q <= '0;
                    end
                end
                ST_UNLOCK: begin
                    if (tmr_zero) begin
                        state_q  <= ST_ENTRY;
                        unlock_q <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    if (tmr_zero) begin
                        state_q <= ST_ENTRY;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_ENTRY;
                    unlock_q <= 1'b0;
                    alarm_q  <= 1'b0;
                end
            endcase
        end
    end

    assign entry_code = entry_q;
    assign digit_cnt  = digit_cnt_q;
    assign unlock     = unlock_q;
    assign alarm      = alarm_q;
    assign err_pulse  = err_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_key_lock_ctrl.sv
// Bench for key_lock_ctrl: directed scenarios plus random key traffic against a
// time-stamp based reference model of the lock behaviour.
module tb_key_lock_ctrl;

    localparam int          PW_LEN = 4;
    localparam int          UC     = 20;
    localparam int          LC     = 50;
    localparam int          IC     = 100;
    localparam int          MAXF   = 3;
    localparam logic [15:0] PW     = 16'h1234;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  key_pulse = '0;
    logic [15:0] entry_code;
    logic [3:0]  digit_cnt;
    logic        unlock;
    logic        alarm;
    logic        err_pulse;
    logic [2:0]  fail_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: digit queue, mode with absolute end time, last key time.
    int m_digits[$];
    int m_mode;
    int m_end;
    int m_last;
    int m_fails;
    bit m_err;
    int cyc = 0;

    always #5 clk = ~clk;

    key_lock_ctrl #(
        .PW_LEN         (PW_LEN),
        .PASSWORD       (PW),
        .MAX_FAIL       (MAXF),
        .UNLOCK_CYCLES  (UC),
        .LOCKOUT_CYCLES (LC),
        .IDLE_CYCLES    (IC),
        .CNT_W          (28)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_pulse  (key_pulse),
        .entry_code (entry_code),
        .digit_cnt  (digit_cnt),
        .unlock     (unlock),
        .alarm      (alarm),
        .err_pulse  (err_pulse),
        .fail_cnt   (fail_cnt)
    );

    function automatic logic [15:0] m_code();
        logic [15:0] c = '0;
        foreach (m_digits[i]) c = (c << 4) | 16'(m_digits[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_mode  = 0;
        m_end   = 0;
        m_last  = cyc;
        m_fails = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic [8:0] k);
        int idx;
        cyc++;
        m_err = 1'b0;
        if (m_mode != 0) begin
            if (cyc == m_end) m_mode = 0;
        end else if ($countones(k) == 1) begin
            idx = 0;
            for (int i = 0; i < 9; i++) if (k[i]) idx = i;
            m_last = cyc;
            if (idx == 8) begin
                if (m_digits.size() == PW_LEN && m_code() == PW) begin
                    m_mode  = 1;
                    m_end   = cyc + UC;
                    m_fails = 0;
                end else begin
                    m_err = 1'b1;
                    m_fails++;
                    if (m_fails == MAXF) begin
                        m_mode  = 2;
                        m_end   = cyc + LC;
                        m_fails = 0;
                    end
                end
                m_digits.delete();
            end else if (m_digits.size() < PW_LEN) begin
                m_digits.push_back(idx + 1);
            end
        end else if (m_digits.size() > 0 && cyc - m_last > IC) begin
            m_digits.delete();
        end
    endtask

    task automatic applyStimulus(input logic [8:0] k);
        key_pulse = k;
        @(posedge clk);
        #1;
        key_pulse = '0;
        model_step(k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (entry_code !== 16'h0) begin errors++; $display("[TB] FAIL reset_entry_code: got %h expected 0", entry_code); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("[TB] FAIL reset_unlock: got %b expected 0", unlock); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarm: got %b expected 0", alarm); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_pulse: got %b expected 0", err_pulse); end
        checks++; if (fail_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_unlock();
        int hi = 0;
        applyStimulus(9'h001); idle(4);
        applyStimulus(9'h002); idle(4);
        applyStimulus(9'h004); idle(4);
        applyStimulus(9'h008); idle(4);
        checks++; if (entry_code !== 16'h1234) begin errors++; $display("[TB] FAIL unlock_entry_code: got %h expected 1234", entry_code); end
        checks++; if (digit_cnt !== 4'd4) begin errors++; $display("[TB] FAIL unlock_digit_cnt: got %0d expected 4", digit_cnt); end
        applyStimulus(9'h100);
        checks++; if (unlock !== 1'b1) begin errors++; $display("[TB] FAIL unlock_first_cycle: got %b expected 1", unlock); end
        checks++; if (fail_cnt !== 3'd0) begin errors++; $display("[TB] FAIL unlock_fail_cnt: got %0d expected 0", fail_cnt); end
        for (int i = 0; i < UC + 5; i++) begin
            if (unlock) hi++;
            checks++; if (unlock !== (m_mode == 1)) begin errors++; $display("[TB] FAIL unlock_window: cycle %0d got %b expected %b", i, unlock, m_mode == 1); end
            applyStimulus('0);
        end
        checks++; if (hi != UC) begin errors++; $display("[TB] FAIL unlock_length: got %0d cycles expected %0d", hi, UC); end
    endtask

    task automatic test_lockout();
        int hi;
        for (int r = 1; r <= MAXF; r++) begin
            applyStimulus(9'h001); applyStimulus(9'h002); applyStimulus(9'h004); applyStimulus(9'h010);
            applyStimulus(9'h100);
            checks++; if (err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL lock_err_pulse: try %0d got %b expected 1", r, err_pulse); end
            checks++; if (fail_cnt !== 3'(r == MAXF ? 0 : r)) begin errors++; $display("[TB] FAIL lock_fail_cnt: try %0d got %0d expected %0d", r, fail_cnt, r == MAXF ? 0 : r); end
            checks++; if (alarm !== (r == MAXF)) begin errors++; $display("[TB] FAIL lock_alarm: try %0d got %b expected %b", r, alarm, r == MAXF); end
            if (r < MAXF) begin
                applyStimulus('0);
                checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL lock_err_width: got %b expected 0", err_pulse); end
            end
        end
        hi = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4 ? 9'h100 : 9'(1 << i));
            if (alarm) hi++;
            checks++; if (unlock !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL lock_keys_ignored: got unlock %b err %b expected 0 0", unlock, err_pulse); end
        end
        for (int i = 0; i < LC + 10; i++) begin
            applyStimulus('0);
            if (alarm) hi++;
        end
        checks++; if (hi != LC) begin errors++; $display("[TB] FAIL lock_alarm_length: got %0d cycles expected %0d", hi, LC); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("[TB] FAIL lock_no_unlock: got %b expected 0", unlock); end
    endtask

    task automatic test_multi_bit();
        applyStimulus(9'h001);
        idle(5);
        applyStimulus(9'h003);
        checks++; if (entry_code !== 16'h0001 || digit_cnt !== 4'd1) begin errors++; $display("[TB] FAIL multi_bit_ignored: got %h/%0d expected 0001/1", entry_code, digit_cnt); end
        idle(IC - 6);
        checks++; if (digit_cnt !== 4'd1) begin errors++; $display("[TB] FAIL multi_bit_before_expiry: got %0d expected 1", digit_cnt); end
        applyStimulus('0);
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("[TB] FAIL multi_bit_no_restart: got %0d expected 0", digit_cnt); end
    endtask

    task automatic test_idle_clear();
        applyStimulus(9'h100);
        checks++; if (fail_cnt !== 3'd1) begin errors++; $display("[TB] FAIL idle_setup_fail_cnt: got %0d expected 1", fail_cnt); end
        applyStimulus(9'h001);
        applyStimulus(9'h002);
        idle(IC);
        checks++; if (entry_code !== 16'h0012 || digit_cnt !== 4'd2) begin errors++; $display("[TB] FAIL idle_before_expiry: got %h/%0d expected 0012/2", entry_code, digit_cnt); end
        applyStimulus('0);
        checks++; if (entry_code !== 16'h0 || digit_cnt !== 4'd0) begin errors++; $display("[TB] FAIL idle_cleared: got %h/%0d expected 0000/0", entry_code, digit_cnt); end
        checks++; if (fail_cnt !== 3'd1) begin errors++; $display("[TB] FAIL idle_fail_kept: got %0d expected 1", fail_cnt); end
    endtask

    task automatic test_overflow();
        applyStimulus(9'h001); applyStimulus(9'h002); applyStimulus(9'h004); applyStimulus(9'h008);
        applyStimulus(9'h080);
        checks++; if (entry_code !== 16'h1234 || digit_cnt !== 4'd4) begin errors++; $display("[TB] FAIL overflow_kept: got %h/%0d expected 1234/4", entry_code, digit_cnt); end
        applyStimulus(9'h100);
        checks++; if (unlock !== 1'b1 || fail_cnt !== 3'd0) begin errors++; $display("[TB] FAIL overflow_unlock: got unlock %b fail %0d expected 1 0", unlock, fail_cnt); end
    endtask

    task automatic test_reset_mid();
        idle(5);
        checks++; if (unlock !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre: got %b expected 1", unlock); end
        rstn = 1'b0;
        #2;
        checks++; if (unlock !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async_drop: got %b expected 0", unlock); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        applyStimulus('0);
        checks++; if ({entry_code, digit_cnt, unlock, alarm, err_pulse, fail_cnt} !== '0) begin errors++; $display("[TB] FAIL rstmid_after: got %h/%0d/%b/%b/%b/%0d expected all 0", entry_code, digit_cnt, unlock, alarm, err_pulse, fail_cnt); end
    endtask

    task automatic test_random();
        logic [8:0] seq [5] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h100};
        logic [8:0] k;
        int seq_pos = -1;
        int gap = 0;
        int r, a, b;
        for (int n = 0; n < 2500; n++) begin
            if (seq_pos >= 0) begin
                k = seq[seq_pos];
                seq_pos = (seq_pos == 4) ? -1 : seq_pos + 1;
            end else if (gap > 0) begin
                k = '0;
                gap--;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 55) k = '0;
                else if (r < 62) begin k = seq[0]; seq_pos = 1; end
                else if (r < 64) begin k = '0; gap = $urandom_range(90, 130); end
                else if (r < 70) begin
                    a = $urandom_range(0, 8);
                    b = (a + $urandom_range(1, 8)) % 9;
                    k = 9'((1 << a) | (1 << b));
                end else k = 9'(1 << $urandom_range(0, 8));
            end
            applyStimulus(k);
            checks++; if (entry_code !== m_code()) begin errors++; $display("[TB] FAIL rnd_entry_code: n %0d got %h expected %h", n, entry_code, m_code()); end
            checks++; if (digit_cnt !== 4'(m_digits.size())) begin errors++; $display("[TB] FAIL rnd_digit_cnt: n %0d got %0d expected %0d", n, digit_cnt, m_digits.size()); end
            checks++; if (unlock !== (m_mode == 1)) begin errors++; $display("[TB] FAIL rnd_unlock: n %0d got %b expected %b", n, unlock, m_mode == 1); end
            checks++; if (alarm !== (m_mode == 2)) begin errors++; $display("[TB] FAIL rnd_alarm: n %0d got %b expected %b", n, alarm, m_mode == 2); end
            checks++; if (err_pulse !== m_err) begin errors++; $display("[TB] FAIL rnd_err_pulse: n %0d got %b expected %b", n, err_pulse, m_err); end
            checks++; if (fail_cnt !== 3'(m_fails)) begin errors++; $display("[TB] FAIL rnd_fail_cnt: n %0d got %0d expected %0d", n, fail_cnt, m_fails); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_unlock();
        test_lockout();
        test_multi_bit();
        test_idle_clear();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
